le_word_packer: RTL and testbench

- Assembles a valid/ready byte stream into little-endian words of `DATA_W` bits: the first byte of each word goes to lane 0, bits [`BYTE`-1:0].
- Sits directly upstream of the le-to-be byte-order converter; its `word_o` drives that stage's little-endian data input.
- Supports early termination with `byte_last_i`, which produces a partial word qualified by per-lane byte enables.
- Sustains one byte per cycle with no bubbles while the consumer keeps `word_ready_i` high.

---
 rtl/le_word_packer_pkg.sv | 25 ++
 rtl/le_word_packer_if.sv | 31 +++
 rtl/le_word_packer_out_reg.sv | 37 +++
 rtl/le_word_packer.sv | 138 +++++++++++++
 tb/tb_le_word_packer.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/le_word_packer_pkg.sv
// Shared types for the little-endian byte packer and the downstream byte-order converter.
// The struct is sized for the default 32-bit word that the converter wrapper consumes.
package le_packer_pkg;

   localparam int BYTE_W = 8;
   localparam int WORD_W = 32;

   function automatic int nbytes_of(input int data_w, input int byte_w);
      return data_w / byte_w;
   endfunction

   localparam int WORD_NBYTES = nbytes_of(WORD_W, BYTE_W);

   typedef enum logic [0:0] {
      FILL = 1'b0,
      HOLD = 1'b1
   } packer_state_e;

   typedef struct packed {
      logic [WORD_W-1:0]      data;
      logic [WORD_NBYTES-1:0] be;
      logic                   last;
   } packed_word_t;

endpackage

// File: rtl/le_word_packer_if.sv
// Byte-stream input and word-stream output of the packer, grouped as one bundle.
// The slave view belongs to the packer; the master view drives bytes and consumes words.
interface le_word_packer_if #(
   parameter int DATA_W = 32,
   parameter int BYTE   = 8
);
   import le_packer_pkg::*;

   localparam int NBYTES = nbytes_of(DATA_W, BYTE);

   logic [BYTE-1:0]   byte_i;
   logic              byte_valid_i;
   logic              byte_last_i;
   logic              byte_ready_o;
   logic [DATA_W-1:0] word_o;
   logic [NBYTES-1:0] word_be_o;
   logic              word_last_o;
   logic              word_valid_o;
   logic              word_ready_i;

   modport slave (
      input  byte_i, byte_valid_i, byte_last_i, word_ready_i,
      output byte_ready_o, word_o, word_be_o, word_last_o, word_valid_o
   );

   modport master (
      output byte_i, byte_valid_i, byte_last_i, word_ready_i,
      input  byte_ready_o, word_o, word_be_o, word_last_o, word_valid_o
   );

endinterface

// File: rtl/le_word_packer_out_reg.sv
// Output holding register of the packer; a load in the same cycle as a take wins,
// so a back-to-back word keeps word_valid asserted without a bubble.
module le_packer_out_reg #(
   parameter int DATA_W = 32,
   parameter int NBYTES = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              take,
   input  logic [DATA_W-1:0] load_data,
   input  logic [NBYTES-1:0] load_be,
   input  logic              load_last,
   output logic [DATA_W-1:0] word,
   output logic [NBYTES-1:0] be,
   output logic              last,
   output logic              valid
);

   // Holding register: load has priority over take, otherwise contents are held.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         word  <= {DATA_W{1'b0}};
         be    <= {NBYTES{1'b0}};
         last  <= 1'b0;
         valid <= 1'b0;
      end else if (load) begin
         word  <= load_data;
         be    <= load_be;
         last  <= load_last;
         valid <= 1'b1;
      end else if (take) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/le_word_packer.sv
// Packs a valid/ready byte stream into little-endian words with per-lane enables;
// byte_last closes a partial word early.
module le_word_packer
   import le_packer_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int BYTE   = 8
) (
   input logic            clk,
   input logic            reset,
   le_word_packer_if.slave bus
);

   localparam int NBYTES = nbytes_of(DATA_W, BYTE);
   localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

   packer_state_e     state_r;
   logic [IDX_W-1:0]  idx_r;
   logic [DATA_W-1:0] acc_r;
   logic [NBYTES-1:0] acc_be_r;
   logic              acc_last_r;

   logic              out_free_s;
   logic              byte_ready_s;
   logic              accept_s;
   logic              complete_s;
   logic              load_s;
   logic              take_s;
   logic [DATA_W-1:0] acc_next_s;
   logic [NBYTES-1:0] be_next_s;
   logic [DATA_W-1:0] load_data_s;
   logic [NBYTES-1:0] load_be_s;
   logic              load_last_s;

   assign out_free_s = !bus.word_valid_o || bus.word_ready_i;
   assign take_s     = bus.word_valid_o && bus.word_ready_i;

   // Next accumulator image, handshake decode and the word offered to the output register.
   always_comb begin
      acc_next_s = acc_r;
      be_next_s  = acc_be_r;
      acc_next_s[int'(idx_r) * BYTE +: BYTE] = bus.byte_i;
      be_next_s[idx_r] = 1'b1;

      // The last lane may only be taken if the finished word can leave immediately.
      if (!reset) begin
         byte_ready_s = 1'b0;
      end else if (state_r == HOLD) begin
         byte_ready_s = 1'b0;
      end else if (idx_r == LAST_IDX) begin
         byte_ready_s = out_free_s;
      end else begin
         byte_ready_s = 1'b1;
      end

      accept_s   = bus.byte_valid_i && byte_ready_s;
      complete_s = accept_s && ((idx_r == LAST_IDX) || bus.byte_last_i);

      case (state_r)
         FILL:    load_s = complete_s && out_free_s;
         HOLD:    load_s = out_free_s;
         default: load_s = 1'b0;
      endcase

      if (state_r == HOLD) begin
         load_data_s = acc_r;
         load_be_s   = acc_be_r;
         load_last_s = acc_last_r;
      end else begin
         load_data_s = acc_next_s;
         load_be_s   = be_next_s;
         load_last_s = bus.byte_last_i;
      end
   end

   assign bus.byte_ready_o = byte_ready_s;

   // FILL/HOLD state machine with the lane index and accumulator.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r    <= FILL;
         idx_r      <= {IDX_W{1'b0}};
         acc_r      <= {DATA_W{1'b0}};
         acc_be_r   <= {NBYTES{1'b0}};
         acc_last_r <= 1'b0;
      end else begin
         case (state_r)
            FILL: begin
               if (complete_s) begin
                  idx_r <= {IDX_W{1'b0}};
                  if (out_free_s) begin
                     acc_r      <= {DATA_W{1'b0}};
                     acc_be_r   <= {NBYTES{1'b0}};
                     acc_last_r <= 1'b0;
                  end else begin
                     acc_r      <= acc_next_s;
                     acc_be_r   <= be_next_s;
                     acc_last_r <= bus.byte_last_i;
                     state_r    <= HOLD;
                  end
               end else if (accept_s) begin
                  idx_r    <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                  acc_r    <= acc_next_s;
                  acc_be_r <= be_next_s;
               end
            end
            HOLD: begin
               if (out_free_s) begin
                  acc_r      <= {DATA_W{1'b0}};
                  acc_be_r   <= {NBYTES{1'b0}};
                  acc_last_r <= 1'b0;
                  state_r    <= FILL;
               end
            end
            default: state_r <= FILL;
         endcase
      end
   end

   le_packer_out_reg #(
      .DATA_W (DATA_W),
      .NBYTES (NBYTES)
   ) u_out_reg (
      .clk       (clk),
      .reset     (reset),
      .load      (load_s),
      .take      (take_s),
      .load_data (load_data_s),
      .load_be   (load_be_s),
      .load_last (load_last_s),
      .word      (bus.word_o),
      .be        (bus.word_be_o),
      .last      (bus.word_last_o),
      .valid     (bus.word_valid_o)
   );

endmodule

// File: tb/tb_le_word_packer.sv
// Self-checking bench for le_word_packer: directed scenarios plus a randomized run
// checked against a byte-queue reference model.
module tb_le_word_packer;

   localparam int NB = 4;

   logic clk = 1'b0;
   logic reset;
   int   pass_cnt = 0;
   int   total_cnt = 0;

   le_word_packer_if #(.DATA_W(32), .BYTE(8)) bus();

   le_word_packer #(.DATA_W(32), .BYTE(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // {valid, last, be, word}
   function automatic logic [37:0] out_vec();
      return {bus.word_valid_o, bus.word_last_o, bus.word_be_o, bus.word_o};
   endfunction

   // Drive one cycle of stimulus at the falling edge, then let it settle.
   task automatic step(input logic [7:0] b, input logic v, input logic l, input logic wr);
      @(negedge clk);
      bus.byte_i       = b;
      bus.byte_valid_i = v;
      bus.byte_last_i  = l;
      bus.word_ready_i = wr;
      #1;
   endtask

   task automatic test_reset();
      #12;
      total_cnt++;
      if (out_vec() !== 38'h0) $display("FAIL reset_outputs: got %h expected %h", out_vec(), 38'h0);
      else pass_cnt++;
      total_cnt++;
      if (bus.byte_ready_o !== 1'b0) $display("FAIL reset_ready: got %b expected 0", bus.byte_ready_o);
      else pass_cnt++;
      @(negedge clk);
      reset = 1'b1;
      #1;
      total_cnt++;
      if (bus.byte_ready_o !== 1'b1) $display("FAIL release_ready: got %b expected 1", bus.byte_ready_o);
      else pass_cnt++;
   endtask

   task automatic test_streaming();
      logic [7:0] bytes [8];
      bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      for (int i = 0; i < 8; i++) begin
         step(bytes[i], 1'b1, 1'b0, 1'b1);
         total_cnt++;
         if (bus.byte_ready_o !== 1'b1) $display("FAIL stream_ready[%0d]: got %b expected 1", i, bus.byte_ready_o);
         else pass_cnt++;
         if (i == 4) begin
            total_cnt++;
            if (out_vec() !== {1'b1, 1'b0, 4'hF, 32'h44332211})
               $display("FAIL stream_word0: got %h expected %h", out_vec(), {1'b1, 1'b0, 4'hF, 32'h44332211});
            else pass_cnt++;
         end
         if (i == 5) begin
            total_cnt++;
            if (bus.word_valid_o !== 1'b0) $display("FAIL stream_gap: got %b expected 0", bus.word_valid_o);
            else pass_cnt++;
         end
      end
      step(8'h00, 1'b0, 1'b0, 1'b1);
      total_cnt++;
      if (out_vec() !== {1'b1, 1'b0, 4'hF, 32'h88776655})
         $display("FAIL stream_word1: got %h expected %h", out_vec(), {1'b1, 1'b0, 4'hF, 32'h88776655});
      else pass_cnt++;
      step(8'h00, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_partial();
      step(8'hAA, 1'b1, 1'b0, 1'b1);
      step(8'hBB, 1'b1, 1'b1, 1'b1);
      step(8'h00, 1'b0, 1'b0, 1'b1);
      total_cnt++;
      if (out_vec() !== {1'b1, 1'b1, 4'b0011, 32'h0000BBAA})
         $display("FAIL partial_word: got %h expected %h", out_vec(), {1'b1, 1'b1, 4'b0011, 32'h0000BBAA});
      else pass_cnt++;
      step(8'h5A, 1'b1, 1'b1, 1'b1);
      step(8'h00, 1'b0, 1'b0, 1'b1);
      total_cnt++;
      if (out_vec() !== {1'b1, 1'b1, 4'b0001, 32'h0000005A})
         $display("FAIL partial_lane0: got %h expected %h", out_vec(), {1'b1, 1'b1, 4'b0001, 32'h0000005A});
      else pass_cnt++;
      step(8'h00, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_backpressure();
      logic [7:0] bytes [7];
      bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
      for (int i = 0; i < 7; i++) begin
         step(bytes[i], 1'b1, 1'b0, 1'b0);
         total_cnt++;
         if (bus.byte_ready_o !== 1'b1) $display("FAIL bp_ready[%0d]: got %b expected 1", i, bus.byte_ready_o);
         else pass_cnt++;
      end
      for (int i = 0; i < 3; i++) begin
         step(8'h88, 1'b1, 1'b0, 1'b0);
         total_cnt++;
         if (bus.byte_ready_o !== 1'b0) $display("FAIL bp_stall_ready[%0d]: got %b expected 0", i, bus.byte_ready_o);
         else pass_cnt++;
         total_cnt++;
         if (out_vec() !== {1'b1, 1'b0, 4'hF, 32'h44332211})
            $display("FAIL bp_stable[%0d]: got %h expected %h", i, out_vec(), {1'b1, 1'b0, 4'hF, 32'h44332211});
         else pass_cnt++;
      end
      step(8'h88, 1'b1, 1'b0, 1'b1);
      total_cnt++;
      if (bus.byte_ready_o !== 1'b1) $display("FAIL bp_release_ready: got %b expected 1", bus.byte_ready_o);
      else pass_cnt++;
      step(8'h00, 1'b0, 1'b0, 1'b1);
      total_cnt++;
      if (out_vec() !== {1'b1, 1'b0, 4'hF, 32'h88776655})
         $display("FAIL bp_word1: got %h expected %h", out_vec(), {1'b1, 1'b0, 4'hF, 32'h88776655});
      else pass_cnt++;
      step(8'h00, 1'b0, 1'b0, 1'b1);
      total_cnt++;
      if (bus.word_valid_o !== 1'b0) $display("FAIL bp_drained: got %b expected 0", bus.word_valid_o);
      else pass_cnt++;
   endtask

   task automatic test_hold();
      for (int i = 0; i < NB; i++) step(8'hD1 + 8'(i), 1'b1, 1'b0, 1'b0);
      step(8'hCC, 1'b1, 1'b1, 1'b0);
      total_cnt++;
      if (bus.byte_ready_o !== 1'b1) $display("FAIL hold_accept_cc: got %b expected 1", bus.byte_ready_o);
      else pass_cnt++;
      step(8'hEE, 1'b1, 1'b0, 1'b0);
      total_cnt++;
      if ({bus.byte_ready_o, out_vec()} !== {1'b0, 1'b1, 1'b0, 4'hF, 32'hD4D3D2D1})
         $display("FAIL hold_stalled: got %h expected %h", {bus.byte_ready_o, out_vec()}, {1'b0, 1'b1, 1'b0, 4'hF, 32'hD4D3D2D1});
      else pass_cnt++;
      step(8'hEE, 1'b1, 1'b0, 1'b1);
      total_cnt++;
      if (bus.byte_ready_o !== 1'b0) $display("FAIL hold_ready_on_release: got %b expected 0", bus.byte_ready_o);
      else pass_cnt++;
      step(8'h00, 1'b0, 1'b0, 1'b0);
      total_cnt++;
      if ({bus.byte_ready_o, out_vec()} !== {1'b1, 1'b1, 1'b1, 4'b0001, 32'h000000CC})
         $display("FAIL hold_word: got %h expected %h", {bus.byte_ready_o, out_vec()}, {1'b1, 1'b1, 1'b1, 4'b0001, 32'h000000CC});
      else pass_cnt++;
      step(8'h00, 1'b0, 1'b0, 1'b1);
      step(8'h00, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_reset_mid_word();
      for (int i = 0; i < NB; i++) step(8'hF1 + 8'(i), 1'b1, 1'b0, 1'b0);
      step(8'hE1, 1'b1, 1'b0, 1'b0);
      step(8'hE2, 1'b1, 1'b0, 1'b0);
      @(posedge clk);
      #2;
      reset = 1'b0;
      bus.byte_valid_i = 1'b0;
      #1;
      total_cnt++;
      if ({bus.byte_ready_o, out_vec()} !== 39'h0)
         $display("FAIL midreset_outputs: got %h expected %h", {bus.byte_ready_o, out_vec()}, 39'h0);
      else pass_cnt++;
      @(negedge clk);
      reset = 1'b1;
      for (int i = 1; i <= NB; i++) begin
         step(8'(i), 1'b1, 1'b0, 1'b1);
         total_cnt++;
         if ({bus.byte_ready_o, bus.word_valid_o} !== 2'b10)
            $display("FAIL midreset_fill[%0d]: got %b expected 10", i, {bus.byte_ready_o, bus.word_valid_o});
         else pass_cnt++;
      end
      step(8'h00, 1'b0, 1'b0, 1'b1);
      total_cnt++;
      if (out_vec() !== {1'b1, 1'b0, 4'hF, 32'h04030201})
         $display("FAIL midreset_word: got %h expected %h", out_vec(), {1'b1, 1'b0, 4'hF, 32'h04030201});
      else pass_cnt++;
      step(8'h00, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_random();
      int         cur [$];
      logic [36:0] exp_q [$];
      logic [36:0] exp_w;
      logic [37:0] prev_vec = '0;
      logic        prev_stall = 1'b0;
      logic [7:0]  b;
      logic        v, l, wr, r1;
      logic [31:0] w;
      for (int c = 0; c < 620; c++) begin
         b = 8'($urandom_range(0, 255));
         if (c < 600) begin
            v  = ($urandom_range(0, 9) < 8);
            l  = ($urandom_range(0, 9) < 2);
            wr = ($urandom_range(0, 9) < 6);
         end else begin
            v  = (cur.size() > 0);
            l  = 1'b1;
            wr = 1'b1;
         end
         step(b, v, l, wr);
         r1 = bus.byte_ready_o;
         bus.byte_valid_i = ~v;
         bus.byte_last_i  = ~l;
         #1;
         total_cnt++;
         if (bus.byte_ready_o !== r1) $display("FAIL rand_ready_indep[%0d]: got %b expected %b", c, bus.byte_ready_o, r1);
         else pass_cnt++;
         bus.byte_valid_i = v;
         bus.byte_last_i  = l;
         #1;
         if (prev_stall) begin
            total_cnt++;
            if (out_vec() !== prev_vec) $display("FAIL rand_stable[%0d]: got %h expected %h", c, out_vec(), prev_vec);
            else pass_cnt++;
         end
         if (bus.word_valid_o && wr) begin
            total_cnt++;
            if (exp_q.size() == 0) begin
               $display("FAIL rand_unexpected_word[%0d]: got %h expected none", c, out_vec());
            end else begin
               exp_w = exp_q.pop_front();
               if ({bus.word_last_o, bus.word_be_o, bus.word_o} !== exp_w)
                  $display("FAIL rand_word[%0d]: got %h expected %h", c, {bus.word_last_o, bus.word_be_o, bus.word_o}, exp_w);
               else pass_cnt++;
            end
         end
         if (v && r1) begin
            cur.push_back(int'(b));
            if (cur.size() == NB || l) begin
               w = 32'h0;
               foreach (cur[i]) w = w | (32'(cur[i]) << (8 * i));
               exp_q.push_back({l, 4'((1 << cur.size()) - 1), w});
               cur.delete();
            end
         end
         prev_vec   = out_vec();
         prev_stall = bus.word_valid_o && !wr;
      end
      total_cnt++;
      if (exp_q.size() != 0 || cur.size() != 0)
         $display("FAIL rand_leftover: got %0d words %0d bytes expected 0 0", exp_q.size(), cur.size());
      else pass_cnt++;
   endtask

   initial begin
      reset            = 1'b0;
      bus.byte_i       = 8'h00;
      bus.byte_valid_i = 1'b0;
      bus.byte_last_i  = 1'b0;
      bus.word_ready_i = 1'b0;
      test_reset();
      test_streaming();
      test_partial();
      test_backpressure();
      test_hold();
      test_reset_mid_word();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
